// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the FSM state encoding, the default operand width and a helper
// that sizes the iteration counter so it can count up to WIDTH.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    FIX,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 64;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in  - partial remainder from the previous step
//   divisor - divisor magnitude
//   bit_in  - next dividend bit, shifted into the partial remainder
//   rem_out - new partial remainder (trial result kept or restored)
//   q_bit   - quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;

  // The partial remainder is always below the divisor magnitude, which is
  // at most 2^(WIDTH-1), so its top bit is zero and the shift loses nothing.
  assign shifted = {rem_in[WIDTH-2:0], bit_in};
  assign q_bit   = (shifted >= divisor);
  assign rem_out = q_bit ? (shifted - divisor) : shifted;

endmodule

// File: rtl/divider.sv
// Sequential signed radix-2 restoring divider, one quotient bit per clock.
// Truncating quotient; remainder carries the sign of the dividend.
// Optional feature macro: DIV_ERR_EN adds the div_err output.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   dividend, divisor   - signed operands, captured when a start is accepted
//   op_start            - level request, honoured only in IDLE
//   op_clear            - synchronous abort/clear, beats op_start
//   op_done             - result valid, held until op_clear
//   quotient, remainder - registered signed results
//   div_err             - (DIV_ERR_EN only) divisor was zero
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_start,
  input  logic             op_clear,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ERR_EN
  ,
  output logic             div_err
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] a);
    return a[WIDTH-1] ? (~a + 1'b1) : a;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] raw_q, raw_d;      // original dividend, returned on divide by zero
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             op_done_q, op_done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ERR_EN
  logic             div_err_q, div_err_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    raw_d       = raw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    op_done_d   = op_done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ERR_EN
    div_err_d   = div_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (op_start) begin
          dvd_d     = mag(dividend);
          dvs_d     = mag(divisor);
          rem_d     = '0;
          raw_d     = dividend;
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
          zero_d    = (divisor == '0);
          cnt_d     = '0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // Dividend bits leave at the top while quotient bits enter at the
        // bottom, so after WIDTH steps dvd holds the quotient magnitude.
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = raw_q;
        end else begin
          // Negating 2^(WIDTH-1) wraps to itself, giving the overflow result.
          quotient_d  = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
          remainder_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
`ifdef DIV_ERR_EN
        div_err_d = zero_q;
`endif
        op_done_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        // Results held; op_start is ignored until op_clear.
      end
      default: state_d = IDLE;
    endcase

    if (op_clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      op_done_d   = 1'b0;
      quotient_d  = '0;
      remainder_d = '0;
`ifdef DIV_ERR_EN
      div_err_d   = 1'b0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      raw_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      op_done_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ERR_EN
      div_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      raw_q       <= raw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      op_done_q   <= op_done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ERR_EN
      div_err_q   <= div_err_d;
`endif
    end
  end

  assign op_done   = op_done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_ERR_EN
  assign div_err   = div_err_q;
`endif

endmodule
